// File: rtl/mem_stage.sv
`timescale 1ns/1ps
// Pipeline MEM stage: request/grant/response data-memory port with lane steering, load extension
// and a registered write-back bundle. mem_size_i: 0=BYTE_S 1=BYTE_U 2=HALF_S 3=HALF_U 4=WORD.
module mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic        mem_re_i,
    input  logic        mem_we_i,
    input  logic [2:0]  mem_size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  sel_rd_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        misalign_o
);

    typedef enum logic [2:0] {
        BYTE_S = 3'd0,
        BYTE_U = 3'd1,
        HALF_S = 3'd2,
        HALF_U = 3'd3,
        WORD   = 3'd4
    } data_size_e;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e     state;
    data_size_e size_q;
    logic [1:0] off_q;
    logic [4:0] rd_q;

    data_size_e size_d;
    logic       is_byte;
    logic       is_half;
    logic       is_word;
    logic       mem_op;
    logic       misaligned;
    logic       accept;
    logic [3:0] be_d;
    logic [31:0] wdata_d;
    logic [31:0] shifted;
    logic [31:0] load_data;

    // Unknown size codes fall through to WORD behaviour.
    always_comb begin
        size_d     = data_size_e'(mem_size_i);
        is_byte    = (size_d == BYTE_S) || (size_d == BYTE_U);
        is_half    = (size_d == HALF_S) || (size_d == HALF_U);
        is_word    = !is_byte && !is_half;
        mem_op     = mem_re_i || mem_we_i;
        misaligned = (is_half && addr_i[0]) || (is_word && (addr_i[1:0] != 2'b00));
        accept     = (state == IDLE) && valid_i && mem_op && !misaligned;
        if (is_byte) begin
            be_d    = 4'b0001 << addr_i[1:0];
            wdata_d = {4{wdata_i[7:0]}};
        end else if (is_half) begin
            be_d    = 4'b0011 << addr_i[1:0];
            wdata_d = {2{wdata_i[15:0]}};
        end else begin
            be_d    = 4'b1111;
            wdata_d = wdata_i;
        end
    end

    always_comb begin
        shifted = dmem_rdata_i >> {off_q, 3'b000};
        case (size_q)
            BYTE_S:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            BYTE_U:  load_data = {24'd0, shifted[7:0]};
            HALF_S:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            HALF_U:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // A grant releases a store immediately; a load is released only by its response.
    always_comb begin
        case (state)
            IDLE:    stall_o = accept;
            REQ:     stall_o = !(dmem_gnt_i && dmem_we_o);
            WAIT:    stall_o = !dmem_rvalid_i;
            default: stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            size_q       <= BYTE_S;
            off_q        <= 2'd0;
            rd_q         <= 5'd0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= 32'd0;
            dmem_be_o    <= 4'd0;
            dmem_wdata_o <= 32'd0;
            wb_valid_o   <= 1'b0;
            wb_rd_o      <= 5'd0;
            wb_data_o    <= 32'd0;
            misalign_o   <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            misalign_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        if (!mem_op) begin
                            wb_valid_o <= 1'b1;
                            wb_rd_o    <= sel_rd_i;
                            wb_data_o  <= addr_i;
                        end else if (misaligned) begin
                            misalign_o <= 1'b1;
                        end else begin
                            state        <= REQ;
                            size_q       <= size_d;
                            off_q        <= addr_i[1:0];
                            rd_q         <= sel_rd_i;
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= mem_we_i;
                            dmem_addr_o  <= {addr_i[31:2], 2'b00};
                            dmem_be_o    <= be_d;
                            dmem_wdata_o <= wdata_d;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        state      <= dmem_we_o ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_i) begin
                        state      <= IDLE;
                        wb_valid_o <= 1'b1;
                        wb_rd_o    <= rd_q;
                        wb_data_o  <= load_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
